// File: rtl/bht_update_ctrl_if.sv
// -----------------------------------------------------------------------------
// bht_update_ctrl_if
// Bundles the fetch lookup port, the branch-resolution update port and the
// counter-array port of bht_update_ctrl.
//   slave  : controller view (drives fetch_ready/data/pred, upd_ready, arr_*
//            write/read controls, init_done; receives requests and arr_dataout)
//   master : environment view (fetch stage, resolve stage and counter array)
// Parameters:
//   s_index : array index width
//   width   : counter width in bits
// -----------------------------------------------------------------------------
interface bht_update_ctrl_if #(
    parameter int s_index = 10,
    parameter int width   = 2
);
    // fetch-stage lookup
    logic               fetch_valid;
    logic [s_index-1:0] fetch_index;
    logic               fetch_ready;
    logic [width-1:0]   fetch_data;
    logic               fetch_pred;

    // branch-resolution update
    logic               upd_valid;
    logic [s_index-1:0] upd_index;
    logic               upd_taken;
    logic               upd_ready;

    // counter array
    logic               arr_load;
    logic [s_index-1:0] arr_rindex;
    logic [s_index-1:0] arr_windex;
    logic [width-1:0]   arr_datain;
    logic [width-1:0]   arr_dataout;

    logic               init_done;

    modport slave (
        input  fetch_valid, fetch_index,
        input  upd_valid, upd_index, upd_taken,
        input  arr_dataout,
        output fetch_ready, fetch_data, fetch_pred,
        output upd_ready,
        output arr_load, arr_rindex, arr_windex, arr_datain,
        output init_done
    );

    modport master (
        output fetch_valid, fetch_index,
        output upd_valid, upd_index, upd_taken,
        output arr_dataout,
        input  fetch_ready, fetch_data, fetch_pred,
        input  upd_ready,
        input  arr_load, arr_rindex, arr_windex, arr_datain,
        input  init_done
    );
endinterface

// File: rtl/bht_update_ctrl.sv
// -----------------------------------------------------------------------------
// bht_update_ctrl
// Owns the write port and shares the single read port of the branch-history
// counter array. After reset it sweeps every entry to init_value, then serves
// fetch lookups and applies queued branch-resolution updates as a two-cycle
// read-modify-write of a saturating counter.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   ctrl : bht_update_ctrl_if.slave (fetch port, update port, array port,
//          init_done)
// Parameters:
//   s_index      : array index width (2**s_index entries)
//   width        : counter width
//   init_value   : value written to every entry by the init sweep
//   fifo_depth   : update queue depth (power of two, >= 2)
//   starve_limit : max cycles a queued update may be held off by fetch (>= 1)
// -----------------------------------------------------------------------------
module bht_update_ctrl #(
    parameter int               s_index      = 10,
    parameter int               width        = 2,
    parameter logic [width-1:0] init_value   = 2'b01,
    parameter int               fifo_depth   = 4,
    parameter int               starve_limit = 8
) (
    input logic              clk,
    input logic              rst,
    bht_update_ctrl_if.slave ctrl
);

    localparam int PW = $clog2(fifo_depth);
    localparam int CW = $clog2(fifo_depth) + 1;
    localparam int SW = $clog2(starve_limit + 1);
    localparam logic [CW-1:0] FIFO_FULL   = CW'(fifo_depth);
    localparam logic [SW-1:0] STARVE_MAX  = SW'(starve_limit);
    localparam logic [width-1:0] CNT_MAX  = {width{1'b1}};

    typedef enum logic [1:0] {INIT, IDLE, RD, WR} state_e;

    // ---------------------------------------------------------------- state
    state_e             state_q, state_d;
    logic [s_index-1:0] init_ptr_q, init_ptr_d;
    logic               init_done_q, init_done_d;
    logic [width-1:0]   rd_q, rd_d;
    logic [SW-1:0]      starve_q, starve_d;

    // update queue
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [s_index-1:0] q_index_q [fifo_depth];
    logic               q_taken_q [fifo_depth];

    // ------------------------------------------------------------ internals
    logic               q_empty, q_full;
    logic               push, pop, take;
    logic [s_index-1:0] head_index;
    logic               head_taken;
    logic [width-1:0]   rmw_result;

    logic               fetch_ready;
    logic               upd_ready;
    logic               arr_load;
    logic [s_index-1:0] arr_rindex, arr_windex;
    logic [width-1:0]   arr_datain;

    assign q_empty    = (count_q == '0);
    assign q_full     = (count_q == FIFO_FULL);
    assign head_index = q_index_q[rd_ptr_q];
    assign head_taken = q_taken_q[rd_ptr_q];

    // Depends only on registered state so the resolve stage never sees a
    // combinational path from its own upd_valid.
    assign upd_ready = !rst && (state_q != INIT) && !q_full;
    assign push      = ctrl.upd_valid && upd_ready;

    // Saturating counter step applied in WR.
    always_comb begin
        rmw_result = rd_q;
        if (head_taken) begin
            if (rd_q != CNT_MAX) rmw_result = rd_q + 1'b1;
        end else begin
            if (rd_q != '0) rmw_result = rd_q - 1'b1;
        end
    end

    // ------------------------------------------- next state and port control
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        init_done_d = init_done_q;
        rd_d        = rd_q;
        starve_d    = starve_q;
        take        = 1'b0;
        pop         = 1'b0;
        fetch_ready = 1'b0;
        arr_load    = 1'b0;
        arr_rindex  = ctrl.fetch_index;
        arr_windex  = '0;
        arr_datain  = '0;

        unique case (state_q)
            INIT: begin
                arr_load   = 1'b1;
                arr_windex = init_ptr_q;
                arr_datain = init_value;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == '1) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                // Drain when fetch is quiet, when the queue would otherwise
                // back-pressure resolve, or when the head has waited too long.
                take = !q_empty &&
                       (!ctrl.fetch_valid || q_full || (starve_q == STARVE_MAX));
                if (take) begin
                    state_d    = RD;
                    starve_d   = '0;
                    arr_rindex = head_index;
                end else begin
                    fetch_ready = 1'b1;
                    starve_d    = q_empty ? '0 : starve_q + 1'b1;
                end
            end
            RD: begin
                arr_rindex = head_index;
                rd_d       = ctrl.arr_dataout;
                state_d    = WR;
            end
            WR: begin
                // Read port goes back to fetch; the array's write bypass
                // returns the new value to a same-index lookup.
                arr_load    = 1'b1;
                arr_windex  = head_index;
                arr_datain  = rmw_result;
                pop         = 1'b1;
                fetch_ready = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = INIT;
        endcase

        // Reset quiets every control output, including a pending WR write.
        if (rst) begin
            pop         = 1'b0;
            fetch_ready = 1'b0;
            arr_load    = 1'b0;
            arr_rindex  = '0;
            arr_windex  = '0;
            arr_datain  = '0;
        end
    end

    // ------------------------------------------------------- queue pointers
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------ registers
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_ptr_q  <= '0;
            init_done_q <= 1'b0;
            rd_q        <= '0;
            starve_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            init_done_q <= init_done_d;
            rd_q        <= rd_d;
            starve_q    <= starve_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: queue storage is not reset; count_q/pointers define which slots
    // are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            q_index_q[wr_ptr_q] <= ctrl.upd_index;
            q_taken_q[wr_ptr_q] <= ctrl.upd_taken;
        end
    end

    // -------------------------------------------------------------- outputs
    assign ctrl.fetch_ready = fetch_ready;
    assign ctrl.fetch_data  = ctrl.arr_dataout;
    assign ctrl.fetch_pred  = ctrl.arr_dataout[width-1];
    assign ctrl.upd_ready   = upd_ready;
    assign ctrl.arr_load    = arr_load;
    assign ctrl.arr_rindex  = arr_rindex;
    assign ctrl.arr_windex  = arr_windex;
    assign ctrl.arr_datain  = arr_datain;
    assign ctrl.init_done   = init_done_q && !rst;

endmodule
